// File: rtl/dmem_store_buffer_if.sv
// dmem_store_buffer_if
// Purpose: bundles the cpu data-bus signals that run between the cpu bus
// master and the data-memory slave.
// Signals:
//   CS              access strobe, sampled on each rising clock edge
//   WR_RD           1 = write, 0 = read (only meaningful while CS=1)
//   ADDR            32-bit byte address
//   Data_BUS_WRITE  32-bit store data
//   Data_BUS_READ   32-bit registered load data returned by the memory
// Modports:
//   master  cpu side (drives the request, receives read data)
//   slave   memory side (receives the request, drives read data)
interface dmem_store_buffer_if;
    logic        CS;
    logic        WR_RD;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;

    modport master (
        output CS,
        output WR_RD,
        output ADDR,
        output Data_BUS_WRITE,
        input  Data_BUS_READ
    );

    modport slave (
        input  CS,
        input  WR_RD,
        input  ADDR,
        input  Data_BUS_WRITE,
        output Data_BUS_READ
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
// Purpose: word-addressed data RAM fronted by a DEPTH-entry store FIFO.
// Writes are enqueued and retire to RAM later; reads complete in one cycle
// and forward the youngest pending store to the same word. The cpu has no
// wait input, so no access ever stalls.
// Ports:
//   CLK       system clock, rising edge
//   Rst       asynchronous, active-low reset
//   bus       slave side of dmem_store_buffer_if (CS, WR_RD, ADDR,
//             Data_BUS_WRITE in; Data_BUS_READ out, registered)
//   wb_count  number of pending store entries (0..DEPTH)
//   wb_empty  high when wb_count == 0
//   bus_err   one-cycle pulse after an out-of-region or misaligned access
// Optional feature (macro DMEM_PERF_CNT_EN):
//   when defined, adds saturating 32-bit counters rd_cnt, wr_cnt, fwd_cnt.
module dmem_store_buffer #(
    parameter int          ADDR_W    = 10,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   CLK,
    input  logic                   Rst,
    dmem_store_buffer_if.slave     bus,
    output logic [$clog2(DEPTH):0] wb_count,
    output logic                   wb_empty,
    output logic                   bus_err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]            rd_cnt,
    output logic [31:0]            wr_cnt,
    output logic [31:0]            fwd_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORDS = 1 << ADDR_W;

    logic              hit;
    logic [ADDR_W-1:0] word_idx;
    logic              rd_valid;
    logic              wr_valid;
    logic              drain;
    logic              fwd_hit;
    logic [31:0]       fwd_data;

    logic [ADDR_W-1:0] fifo_idx_q  [DEPTH];
    logic [ADDR_W-1:0] fifo_idx_d  [DEPTH];
    logic [31:0]       fifo_data_q [DEPTH];
    logic [31:0]       fifo_data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              bus_err_q, bus_err_d;

    logic [31:0]       ram [WORDS];

    assign hit      = (bus.ADDR[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) &&
                      (bus.ADDR[1:0] == 2'b00);
    assign word_idx = bus.ADDR[ADDR_W+1:2];
    assign rd_valid = bus.CS && !bus.WR_RD && hit;
    assign wr_valid = bus.CS && bus.WR_RD && hit;

    // A read owns the RAM port, so it always blocks retirement. Otherwise
    // the head retires on idle edges, and on a write edge only when the FIFO
    // is full, so the incoming store has a slot and nothing ever overflows.
    assign drain = !rd_valid && (count_q != '0) &&
                   (!wr_valid || (count_q == CNT_W'(DEPTH)));

    // Walk the valid entries from oldest to youngest; a later match
    // overrides an earlier one, leaving the youngest store to this word.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (fifo_idx_q[head_q + PTR_W'(i)] == word_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data_q[head_q + PTR_W'(i)];
            end
        end
    end

    always_comb begin
        fifo_idx_d  = fifo_idx_q;
        fifo_data_d = fifo_data_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        bus_err_d   = bus.CS && !hit;

        if (rd_valid) begin
            rd_data_d = fwd_hit ? fwd_data : ram[word_idx];
        end

        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end

        // When full, tail equals head: the slot being retired this edge is
        // refilled, and the RAM write below still sees the old contents.
        if (wr_valid) begin
            fifo_idx_d[tail_q]  = word_idx;
            fifo_data_d[tail_q] = bus.Data_BUS_WRITE;
            tail_d              = tail_q + PTR_W'(1);
        end

        case ({wr_valid, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_idx_q[i]  <= '0;
                fifo_data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            fifo_idx_q  <= fifo_idx_d;
            fifo_data_q <= fifo_data_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (drain) begin
            ram[fifo_idx_q[head_q]] <= fifo_data_q[head_q];
        end
    end

    assign bus.Data_BUS_READ = rd_data_q;
    assign wb_count          = count_q;
    assign wb_empty          = (count_q == '0);
    assign bus_err           = bus_err_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_cnt_q,  rd_cnt_d;
    logic [31:0] wr_cnt_q,  wr_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        fwd_cnt_d = fwd_cnt_q;
        if (rd_valid && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (wr_valid && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
        if (rd_valid && fwd_hit && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            fwd_cnt_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            fwd_cnt_q <= fwd_cnt_d;
        end
    end

    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign fwd_cnt = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer
// Purpose: self-checking bench for dmem_store_buffer. Stimulus pushes the
// expected post-edge outputs (computed by a queue-based memory model) into a
// scoreboard; an independent monitor pops and compares after every edge.
`timescale 1ns/1ps
module tb_dmem_store_buffer;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic        CLK;
    logic        Rst;
    logic [2:0]  wb_count;
    logic        wb_empty;
    logic        bus_err;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
    logic [31:0] fwd_cnt;
`endif

    dmem_store_buffer_if bus ();

    dmem_store_buffer #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .CLK      (CLK),
        .Rst      (Rst),
        .bus      (bus),
        .wb_count (wb_count),
        .wb_empty (wb_empty),
        .bus_err  (bus_err)
`ifdef DMEM_PERF_CNT_EN
        ,
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt),
        .fwd_cnt  (fwd_cnt)
`endif
    );

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [31:0]       data;
    } store_t;

    typedef struct {
        logic [31:0] rd;
        int          cnt;
        logic        err;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    store_t      pend[$];
    exp_t        exp_q[$];
    logic [31:0] model_ram [1 << ADDR_W];
    logic [31:0] exp_rd = '0;
    int          m_rd  = 0;
    int          m_wr  = 0;
    int          m_fwd = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want $finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic modelReset();
        pend.delete();
        exp_rd = '0;
        m_rd   = 0;
        m_wr   = 0;
        m_fwd  = 0;
    endtask

    // Memory model: pending stores are a plain queue; reads search it newest
    // first, otherwise fall back to the RAM array.
    task automatic modelStep(input logic cs, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        logic              hit;
        logic [ADDR_W-1:0] idx;
        logic              vrd;
        logic              vwr;
        bit                found;
        store_t            s;
        exp_t              e;
        hit   = (addr[31:ADDR_W+2] == '0) && (addr[1:0] == 2'b00);
        idx   = addr[ADDR_W+1:2];
        vrd   = cs && !wr && hit;
        vwr   = cs && wr && hit;
        found = 1'b0;
        if (vrd) begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (!found && pend[i].idx == idx) begin
                    exp_rd = pend[i].data;
                    found  = 1'b1;
                end
            end
            if (!found) exp_rd = model_ram[idx];
            m_rd++;
            if (found) m_fwd++;
        end
        if (!vrd && pend.size() > 0 && (!vwr || pend.size() == DEPTH)) begin
            model_ram[pend[0].idx] = pend[0].data;
            void'(pend.pop_front());
        end
        if (vwr) begin
            s.idx  = idx;
            s.data = data;
            pend.push_back(s);
            m_wr++;
        end
        e.rd  = exp_rd;
        e.cnt = pend.size();
        e.err = cs && !hit;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic cs, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLK);
        bus.CS             = cs;
        bus.WR_RD          = wr;
        bus.ADDR           = addr;
        bus.Data_BUS_WRITE = data;
        modelStep(cs, wr, addr, data);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'($urandom), $urandom, $urandom);
    endtask

    task automatic settle();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: one expectation per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_rd_data", bus.Data_BUS_READ, e.rd);
                checkOutput("sb_wb_count", 32'(wb_count), 32'(e.cnt));
                checkOutput("sb_wb_empty", 32'(wb_empty), 32'(e.cnt == 0));
                checkOutput("sb_bus_err", 32'(bus_err), 32'(e.err));
            end
        end
    end

    initial begin
        int          seq [5];
        int          op;
        logic [31:0] a;

        seq = '{1, 2, 3, 4, 4};
        Rst                = 1'b0;
        bus.CS             = 1'b0;
        bus.WR_RD          = 1'b0;
        bus.ADDR           = '0;
        bus.Data_BUS_WRITE = '0;

        #199;
        checkOutput("in_reset_count", 32'(wb_count), 32'd0);
        checkOutput("in_reset_empty", 32'(wb_empty), 32'd1);
        @(negedge CLK);
        Rst = 1'b1;
        settle();
        checkOutput("reset_rd", bus.Data_BUS_READ, 32'd0);
        checkOutput("reset_count", 32'(wb_count), 32'd0);
        checkOutput("reset_empty", 32'(wb_empty), 32'd1);
        checkOutput("reset_err", 32'(bus_err), 32'd0);

        // Give words 0..63 known contents.
        for (int k = 0; k < 64; k++) applyStimulus(1'b1, 1'b1, 32'(k * 4), $urandom);
        repeat (5) idleCycle();

        // Write then read the same word.
        applyStimulus(1'b1, 1'b1, 32'h10, 32'h1DAA);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
        settle();
        checkOutput("fwd_rd", bus.Data_BUS_READ, 32'h1DAA);
        checkOutput("fwd_count", 32'(wb_count), 32'd1);
        idleCycle();
        settle();
        checkOutput("fwd_drained", 32'(wb_count), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
        settle();
        checkOutput("ram_rd", bus.Data_BUS_READ, 32'h1DAA);

        // Five writes into a four-entry FIFO.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, 32'(k * 4), 32'(k + 1));
            settle();
            checkOutput("full_count", 32'(wb_count), 32'(seq[k]));
        end
        repeat (4) idleCycle();
        settle();
        checkOutput("full_empty", 32'(wb_empty), 32'd1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 32'(k * 4), 32'h0);
            settle();
            checkOutput("full_ram", bus.Data_BUS_READ, 32'(k + 1));
        end

        // Youngest store wins; reads block draining.
        applyStimulus(1'b1, 1'b1, 32'h20, 32'hAAAA);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'hBBBB);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
            settle();
            checkOutput("prio_rd", bus.Data_BUS_READ, 32'hBBBB);
            checkOutput("prio_count", 32'(wb_count), 32'd2);
        end
        repeat (2) idleCycle();
        settle();
        checkOutput("prio_drained", 32'(wb_count), 32'd0);

        // Out-of-region read, then misaligned write.
        applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0);
        settle();
        checkOutput("oor_err", 32'(bus_err), 32'd1);
        checkOutput("oor_rd", bus.Data_BUS_READ, 32'hBBBB);
        checkOutput("oor_count", 32'(wb_count), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0002, 32'h1234);
        settle();
        checkOutput("mis_err", 32'(bus_err), 32'd1);
        checkOutput("mis_count", 32'(wb_count), 32'd0);
        idleCycle();
        settle();
        checkOutput("err_pulse_end", 32'(bus_err), 32'd0);

        // Reset while three stores are pending.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 32'(32'h30 + k * 4), 32'hDEAD_0000 + 32'(k));
        settle();
        checkOutput("pre_rst_count", 32'(wb_count), 32'd3);
        @(negedge CLK);
        Rst    = 1'b0;
        bus.CS = 1'b0;
        #1;
        checkOutput("async_rst_count", 32'(wb_count), 32'd0);
        checkOutput("async_rst_empty", 32'(wb_empty), 32'd1);
        checkOutput("async_rst_rd", bus.Data_BUS_READ, 32'd0);
        modelReset();
        repeat (3) @(negedge CLK);
        Rst = 1'b1;
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 32'(32'h30 + k * 4), 32'h0);

        // Randomized traffic over a small set of words.
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 99);
            a  = 32'($urandom_range(0, 15)) << 2;
            if (op < 5)       a = 32'h0000_1000 + (32'($urandom_range(0, 255)) << 2);
            else if (op < 10) a = a | 32'($urandom_range(1, 3));
            if (op % 5 == 4)  idleCycle();
            else              applyStimulus(1'b1, 1'(op % 2), a, $urandom);
        end
        repeat (6) idleCycle();

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge CLK);
        #3;
        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
`ifdef DMEM_PERF_CNT_EN
        checkOutput("perf_rd", rd_cnt, 32'(m_rd));
        checkOutput("perf_wr", wr_cnt, 32'(m_wr));
        checkOutput("perf_fwd", fwd_cnt, 32'(m_fwd));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
